// File: rtl/slsu.sv
// rtl/slsu.sv - RV32I load/store unit: bounds-checked memory access with a response handshake.
// Optional feature macro: MISALIGN_SPLIT_EN (misaligned accesses become sequential byte cycles).
module slsu #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, SPLIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
`endif

  // One extra bit so that addr+N-1 wrapping past the top of the address space still compares high.
  localparam logic [DATA_WIDTH:0] LIMIT = (DATA_WIDTH+1)'(MEM_SIZE - 3);

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
`ifdef MISALIGN_SPLIT_EN
  logic [1:0]            cnt_q;
  logic [1:0]            last_cnt;
  logic [DATA_WIDTH-1:0] cnt_wide;
`endif

  logic                  f3_ok;
  logic                  aligned;
  logic                  oob;
  logic                  bad;
  logic                  accept;
  logic [2:0]            nbytes;
  logic [DATA_WIDTH:0]   span;
  logic [DATA_WIDTH-1:0] load_data;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                   input logic [DATA_WIDTH-1:0] d);
    case (f3)
      3'b000:  extend = {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  extend = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b100:  extend = {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  extend = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    f3_ok   = 1'b0;
    nbytes  = 3'd4;
    aligned = 1'b1;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we_i;
      default:                f3_ok = 1'b0;
    endcase
    case (req_funct3_i[1:0])
      2'b00: begin
        nbytes  = 3'd1;
        aligned = 1'b1;
      end
      2'b01: begin
        nbytes  = 3'd2;
        aligned = !req_addr_i[0];
      end
      default: begin
        nbytes  = 3'd4;
        aligned = (req_addr_i[1:0] == 2'b00);
      end
    endcase
    span = {1'b0, req_addr_i} + {{(DATA_WIDTH-2){1'b0}}, nbytes - 3'd1};
    if (aligned) oob = ({1'b0, req_addr_i} >= LIMIT);
    else         oob = (span >= LIMIT);
`ifdef MISALIGN_SPLIT_EN
    bad = !f3_ok || oob;
`else
    bad = !f3_ok || oob || !aligned;
`endif
  end

  assign accept = req_valid_i && req_ready_o;

`ifdef MISALIGN_SPLIT_EN
  assign last_cnt = {funct3_q[1], funct3_q[1] | funct3_q[0]};
  assign cnt_wide = {{(DATA_WIDTH-2){1'b0}}, cnt_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)          state_next = RESP;
`ifdef MISALIGN_SPLIT_EN
          else if (!aligned) state_next = SPLIT;
`endif
          else              state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
`ifdef MISALIGN_SPLIT_EN
      SPLIT:  if (cnt_q == last_cnt) state_next = RESP;
`endif
      RESP:   if (resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef MISALIGN_SPLIT_EN
      cnt_q    <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            err_q    <= bad;
            rdata_q  <= '0;
`ifdef MISALIGN_SPLIT_EN
            cnt_q    <= 2'd0;
`endif
          end
        end
        ACCESS: if (!we_q) rdata_q <= mem_rdata_i;
`ifdef MISALIGN_SPLIT_EN
        SPLIT: begin
          // Each byte cycle returns its byte in lane 0; assemble little-endian.
          if (!we_q) rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i[7:0];
          cnt_q <= cnt_q + 2'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign load_data = extend(funct3_q, rdata_q);

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_size_o   = 2'b00;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state)
      IDLE: req_ready_o = !rst;
      ACCESS: begin
        mem_read_o  = !we_q;
        mem_write_o = we_q;
        mem_size_o  = funct3_q[1:0];
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
      end
`ifdef MISALIGN_SPLIT_EN
      SPLIT: begin
        mem_read_o       = !we_q;
        mem_write_o      = we_q;
        mem_size_o       = 2'b00;
        mem_addr_o       = addr_q + cnt_wide;
        mem_wdata_o[7:0] = wdata_q[{cnt_q, 3'b000} +: 8];
      end
`endif
      RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        if (!err_q && !we_q) resp_rdata_o = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/slsu.md
SLSU -- requirements
Module: slsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter MEM_SIZE, default 1024, data-memory size in bytes for bounds checks.
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid_i in 1, req_ready_o out 1: pipeline request handshake.
REQ-006 SHALL have ports req_we_i in 1 (1=store), req_funct3_i in 3 (RV32I width/sign code), req_addr_i in 32, req_wdata_i in 32.
REQ-007 SHALL have ports resp_valid_o out 1, resp_ready_i in 1, resp_rdata_o out 32, resp_err_o out 1.
REQ-008 SHALL have data-memory initiator ports mem_read_o out 1, mem_write_o out 1, mem_size_o out 2 (00 byte, 01 half, 10 word), mem_addr_o out 32, mem_wdata_o out 32, mem_rdata_i in 32 (combinational read, same cycle).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, SPLIT, RESP; req_ready_o=1 only in IDLE.
REQ-010 SHALL accept a request on a rising edge with req_valid_i&req_ready_o, registering we/funct3/addr/wdata.
REQ-011 SHALL decode loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores 000 SB, 001 SH, 010 SW; N = 1/2/4 bytes.
REQ-012 SHALL treat any other funct3 as error: IDLE->RESP, resp_err_o=1, no memory strobe.
REQ-013 SHALL flag out-of-bounds as error (no strobe): aligned when addr >= MEM_SIZE-3; split when addr+N-1 >= MEM_SIZE-3, computed in 33 bits so wrap-around past 0xFFFFFFFF errors.
REQ-014 SHALL go IDLE->ACCESS for aligned (addr mod N == 0) valid requests; ACCESS lasts exactly one cycle with mem_read_o or mem_write_o=1, mem_size_o per N, mem_addr_o=addr, mem_wdata_o=wdata; then ->RESP.
REQ-015 SHALL capture mem_rdata_i at end of ACCESS and re-extend from bit 7 or 15 per funct3 (sign for LB/LH, zero for LBU/LHU), ignoring upper bits from memory.
REQ-016 SHALL go IDLE->SPLIT for misaligned valid requests: N consecutive cycles, cycle k drives mem_size_o=00, mem_addr_o=addr+k, mem_wdata_o[7:0]=wdata byte k (upper bits 0), byte k captured into result bits [8k+7:8k]; after k=N-1 ->RESP.
REQ-017 SHALL, in RESP, hold resp_valid_o=1 with stable resp_rdata_o/resp_err_o until resp_ready_i=1, then ->IDLE on that edge.
REQ-018 SHALL set resp_rdata_o=0 for stores and error responses.
REQ-019 SHALL give latency (accept edge T): aligned resp_valid_o at T+2; split half T+3, split word T+5; error T+1.
REQ-020 SHALL keep mem_read_o=mem_write_o=0 in IDLE and RESP; never assert both.
REQ-021 SHALL ignore req_valid_i outside IDLE; a new request may be accepted the cycle after the response handshake.

Reset
REQ-022 SHALL on rst=1 immediately (asynchronously) enter IDLE, drive req_ready_o=0 while rst high, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_read_o=0, mem_write_o=0, mem_size_o=00, mem_addr_o=0, mem_wdata_o=0.
REQ-023 SHALL drop any in-flight transaction on reset mid-ACCESS/SPLIT/RESP with no response; partial split stores already written stay written.
REQ-024 SHALL assert req_ready_o in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with MISALIGN_SPLIT_EN defined, handle misaligned accesses per REQ-016.
REQ-026 SHALL, without MISALIGN_SPLIT_EN, route misaligned requests IDLE->RESP with resp_err_o=1, no memory strobe, SPLIT state and byte counter absent.

Verification
REQ-027 SHALL cover SW addr 0x10 wdata 0xCAFEBABE, then LW 0x10 -> one write cycle size 10, then resp_rdata_o=0xCAFEBABE at T+2.
REQ-028 SHALL cover memory bytes 0x80,0xFF at 0x20/0x21: LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x20 -> 0xFFFFFF80.
REQ-029 SHALL cover (split build) SW addr 0x41 wdata 0x11223344 -> four byte writes at 0x41..0x44 data 44,33,22,11 on consecutive cycles; LW 0x41 -> 0x11223344 at T+5.
REQ-030 SHALL cover LW addr 0x3FD with MEM_SIZE 1024 -> no strobe, resp_err_o=1 at T+1; funct3 011 -> same.
REQ-031 SHALL cover resp_ready_i held 0 for 3 cycles -> resp_valid_o and data stable, req_ready_o=0, new req_valid_i ignored.
REQ-032 SHALL cover rst pulse during SPLIT cycle k=1 -> strobes drop same cycle, no resp_valid_o, req_ready_o=1 after release.
